// File: rtl/delay_reflections_ramp_bank.sv
// Bank of NCH reflection channels, each with a soft-ramped 9-bit gain (unity = 256),
// per-channel mute and a saturating attenuator. Optional summed output under DELAY_REFLECTIONS_MIX_EN.
module delay_reflections_ramp_bank #(
  parameter int DWIDTH     = 16,
  parameter int NCH        = 4,
  parameter int RAMP_STEP  = 1,
  parameter int LEVEL_COMP = 0,
  parameter int UNMUTE_EN  = 1
) (
  input  logic                    clk_i,
  input  logic                    arst_n_i,
  input  logic                    sample_tick_i,
  input  logic [NCH*8-1:0]        level_i,
  input  logic [NCH-1:0]          mute_i,
  input  logic                    unmute_trigger_i,
  input  logic [NCH*DWIDTH-1:0]   data_i,
  output logic [NCH*DWIDTH-1:0]   data_o,
`ifdef DELAY_REFLECTIONS_MIX_EN
  output logic [DWIDTH-1:0]       mix_o,
`endif
  output logic                    valid_o,
  output logic [NCH-1:0]          busy_o
);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_RAMP_UP   = 2'd1;
  localparam logic [1:0] ST_RAMP_DOWN = 2'd2;
  localparam logic [1:0] ST_MUTED     = 2'd3;

  // Product width: DWIDTH sample times a 10-bit signed (always non-negative) gain.
  localparam int PW = DWIDTH + 10;
  localparam logic signed [PW-1:0] SAT_MAX = {{(PW-DWIDTH+1){1'b0}}, {(DWIDTH-1){1'b1}}};
  localparam logic signed [PW-1:0] SAT_MIN = {{(PW-DWIDTH+1){1'b1}}, {(DWIDTH-1){1'b0}}};

  logic trigger;
  assign trigger = (UNMUTE_EN != 0) && unmute_trigger_i;

  function automatic logic [1:0] next_state(input logic [8:0] g, input logic [8:0] t);
    if (g < t)           return ST_RAMP_UP;
    else if (g > t)      return ST_RAMP_DOWN;
    else if (t == 9'd0)  return ST_MUTED;
    else                 return ST_IDLE;
  endfunction

`ifdef DELAY_REFLECTIONS_MIX_EN
  logic [NCH*DWIDTH-1:0] sat_all;
`endif

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic [8:0]              gain_q, gain_d, target;
    logic [1:0]              state_q, state_d;
    logic [9:0]              level_sum, up_sum;
    logic signed [PW-1:0]    din_ext, gain_ext, prod, shifted;
    logic [DWIDTH-1:0]       sat, data_q;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
      level_sum = {2'b00, level_i[8*k +: 8]} + 10'(LEVEL_COMP);
      target    = 9'd0;
      if (!mute_i[k]) target = (level_sum > 10'd511) ? 9'd511 : level_sum[8:0];

      up_sum  = {1'b0, gain_q} + 10'(RAMP_STEP);
      gain_d  = gain_q;
      state_d = state_q;
      if (trigger) begin
        gain_d  = 9'd0;
        state_d = next_state(9'd0, target);
      end else if (sample_tick_i) begin
        if (gain_q < target)
          gain_d = (up_sum > {1'b0, target}) ? target : up_sum[8:0];
        else if (gain_q > target)
          gain_d = ({1'b0, gain_q} >= {1'b0, target} + 10'(RAMP_STEP)) ?
                   (gain_q - 9'(RAMP_STEP)) : target;
        state_d = next_state(gain_d, target);
      end
    end

    // Attenuation uses the gain held before this tick's update.
    always_comb begin
      din_ext  = PW'($signed(data_i[k*DWIDTH +: DWIDTH]));
      gain_ext = PW'($signed({1'b0, gain_q}));
      prod     = din_ext * gain_ext;
      shifted  = prod >>> 8;
      if (shifted > SAT_MAX)      sat = SAT_MAX[DWIDTH-1:0];
      else if (shifted < SAT_MIN) sat = SAT_MIN[DWIDTH-1:0];
      else                        sat = shifted[DWIDTH-1:0];
    end

    // NOTE: sequential state uses non-blocking assignments so all channels see pre-edge values.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
        gain_q  <= 9'd0;
        state_q <= ST_MUTED;
        data_q  <= '0;
      end else begin
        gain_q  <= gain_d;
        state_q <= state_d;
        if (sample_tick_i) data_q <= sat;
      end
    end

    assign data_o[k*DWIDTH +: DWIDTH] = data_q;
    assign busy_o[k] = (state_q == ST_RAMP_UP) || (state_q == ST_RAMP_DOWN);
`ifdef DELAY_REFLECTIONS_MIX_EN
    assign sat_all[k*DWIDTH +: DWIDTH] = sat;
`endif
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) valid_o <= 1'b0;
    else           valid_o <= sample_tick_i;
  end

`ifdef DELAY_REFLECTIONS_MIX_EN
  // Sum width grows by log2(NCH)+1 so the accumulation itself never wraps.
  localparam int MW = DWIDTH + $clog2(NCH) + 1;
  localparam logic signed [MW-1:0] MIX_MAX = {{(MW-DWIDTH+1){1'b0}}, {(DWIDTH-1){1'b1}}};
  localparam logic signed [MW-1:0] MIX_MIN = {{(MW-DWIDTH+1){1'b1}}, {(DWIDTH-1){1'b0}}};

  logic signed [MW-1:0] mix_sum;
  logic [DWIDTH-1:0]    mix_sat;

  always_comb begin
    mix_sum = '0;
    for (int i = 0; i < NCH; i++)
      mix_sum = mix_sum + MW'($signed(sat_all[i*DWIDTH +: DWIDTH]));
    if (mix_sum > MIX_MAX)      mix_sat = MIX_MAX[DWIDTH-1:0];
    else if (mix_sum < MIX_MIN) mix_sat = MIX_MIN[DWIDTH-1:0];
    else                        mix_sat = mix_sum[DWIDTH-1:0];
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i)          mix_o <= '0;
    else if (sample_tick_i) mix_o <= mix_sat;
  end
`endif

endmodule

// File: doc/delay_reflections_ramp_bank.md
DELAY_REFLECTIONS_RAMP_BANK -- requirements
Module: delay_reflections_ramp_bank

Interface
REQ-001 Parameter DWIDTH, default 16: signed sample width per channel.
REQ-002 Parameter NCH, default 4: number of independent reflection channels (1..16).
REQ-003 Parameter RAMP_STEP, default 1: gain change per sample tick while ramping (1..64).
REQ-004 Parameter LEVEL_COMP, default 0: unsigned 8-bit offset added to every channel's level.
REQ-005 Parameter UNMUTE_EN, default 1: 1 enables unmute_trigger_i; 0 ignores it.
REQ-006 clk_i  input  1  sole clock; all state on rising edge.
REQ-007 arst_n_i  input  1  reset, asynchronous assert, active-low.
REQ-008 sample_tick_i  input  1  one-cycle strobe per audio sample.
REQ-009 level_i  input  NCH*8  per-channel unsigned level, channel k at [8k+7:8k].
REQ-010 mute_i  input  NCH  per-channel level-sensitive mute request.
REQ-011 unmute_trigger_i  input  1  pulse; restarts every channel's ramp from zero gain.
REQ-012 data_i  input  NCH*DWIDTH  signed samples, channel k at [DWIDTH*k+DWIDTH-1:DWIDTH*k].
REQ-013 data_o  output  NCH*DWIDTH  attenuated signed samples, same packing.
REQ-014 valid_o  output  1  one-cycle strobe marking new data_o.
REQ-015 busy_o  output  NCH  channel k ramping (state RAMP_UP or RAMP_DOWN).

Function
REQ-016 Per channel: 9-bit gain g, unity = 256, range 0..511.
REQ-017 Target t = 0 when mute_i[k]=1, else min({1'b0,level_i[k]} + LEVEL_COMP, 511).
REQ-018 Gain update only on sample_tick_i: g<t -> g=min(g+RAMP_STEP,t); g>t -> g=max(g-RAMP_STEP,t); g==t -> hold.
REQ-019 Per-channel FSM states IDLE, RAMP_UP, RAMP_DOWN, MUTED, evaluated after each gain update.
REQ-020 Transitions: g<t -> RAMP_UP; g>t -> RAMP_DOWN; g==t and t==0 -> MUTED; g==t and t>0 -> IDLE.
REQ-021 Target changing mid-ramp redirects the ramp on the next tick; no overshoot past t.
REQ-022 unmute_trigger_i (UNMUTE_EN=1) sets all g to 0 that cycle; trigger wins over a simultaneous tick (no gain step that cycle).
REQ-023 On sample_tick_i, sample k = sat_DWIDTH((data_i[k] * g_current) >>> 8), g_current = gain before this tick's update.
REQ-024 Shift is arithmetic; saturation clamps to +(2^(DWIDTH-1)-1) / -(2^(DWIDTH-1)).
REQ-025 data_o registered, updated only on the cycle after sample_tick_i; held otherwise.
REQ-026 valid_o = 1 exactly one cycle after each sample_tick_i; latency 1 clock.
REQ-027 Back-to-back ticks on consecutive cycles SHALL each produce a valid_o and a gain step.

Reset
REQ-028 arst_n_i low: all g = 0, all FSMs MUTED, data_o = 0, valid_o = 0, busy_o = 0, mix_o = 0.
REQ-029 After release, channels ramp from 0 to target at RAMP_STEP per tick (soft start).
REQ-030 Reset asserted mid-ramp aborts immediately with REQ-028 values; no partial state retained.

Configuration
REQ-031 Macro DELAY_REFLECTIONS_MIX_EN defined: extra output mix_o (DWIDTH, signed) = saturated sum of all NCH attenuated samples, registered alongside data_o, same valid_o.
REQ-032 Macro undefined: mix_o port and summing adder absent; all other behaviour identical.

Verification
REQ-033 Reset, level=128 all, no mute, 200 ticks with RAMP_STEP=1 -> gain reaches 128 at tick 128, busy_o clears, data_i=1000 gives data_o=500.
REQ-034 Steady g=256, assert mute_i[0] -> ch0 gain drops 1/tick, MUTED after 256 ticks, data_o[0]=0; other channels unchanged.
REQ-035 level=255, LEVEL_COMP=200 -> target 455; data_i=+30000 with DWIDTH=16 -> data_o saturates at 32767.
REQ-036 unmute_trigger_i and sample_tick_i same cycle at g=200 -> g=0, no step, next tick g=RAMP_STEP; UNMUTE_EN=0 -> g unchanged.
REQ-037 Ticks on consecutive cycles -> valid_o high two consecutive cycles, two gain steps, data_o matches model.
REQ-038 With DELAY_REFLECTIONS_MIX_EN, NCH=4, g=256, each data_i=+10000 -> mix_o=32767; unequal signs sum exactly.
